// File: rtl/closest_hit_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : closest_hit_accumulator
// Purpose  : Folds the per-cycle batch results of one ray into a single final
//            hit record. Closest-hit mode keeps the hit with the smallest T.
//            Any-hit mode keeps the first hit it sees and then drains the
//            remaining batches. The result is offered to shading over a
//            valid/ready handshake.
// Ports    : clk, reset (async, active-high)
//            start / start_any / start_ready  - ray start handshake and mode
//            in_valid / in_ready / in_hit / in_last - batch result stream
//            out_valid / out_ready / out_hit   - final result handshake
//            out_batches                       - accepted batches (saturating)
//            out_early                         - any-hit terminated early
// Hit layout (HIT_W = 81): {bHit[80], T[79:48] (Q16.16 signed),
//            PI[47:32], Bary[31:0]}. Only bHit and T are interpreted.
// Revision : 1.0 - initial release
// ============================================================================
module closest_hit_accumulator #(
  parameter  int CNT_W = 8,
  localparam int HIT_W = 81
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             start_any,
  output logic             start_ready,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [HIT_W-1:0] in_hit,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [HIT_W-1:0] out_hit,
  output logic [CNT_W-1:0] out_batches,
  output logic             out_early
);

  typedef logic signed [31:0] fixed_t;

  typedef struct packed {
    logic        bHit;
    fixed_t      T;
    logic [15:0] PI;
    logic [31:0] Bary;
  } HitData;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // Largest representable Q16.16 value stands in for "no hit yet".
  function automatic fixed_t FixedInf();
    return 32'sh7FFF_FFFF;
  endfunction

  function automatic HitData hit_cleared();
    HitData h;
    h      = '0;
    h.T    = FixedInf();
    return h;
  endfunction

  state_t             state_q, state_d;
  HitData             acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               any_q, any_d;
  logic               early_q, early_d;

  HitData             w_in;
  logic               w_accept;
  logic               w_closer;

  assign w_in     = in_hit;
  assign w_accept = in_valid && in_ready;
  // Strictly closer only: an equal T keeps the earlier batch.
  assign w_closer = w_in.bHit && ($signed(acc_q.T) > $signed(w_in.T));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      acc_q   <= hit_cleared();
      cnt_q   <= '0;
      any_q   <= 1'b0;
      early_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      any_q   <= any_d;
      early_q <= early_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    any_d   = any_q;
    early_d = early_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          acc_d   = hit_cleared();
          cnt_d   = '0;
          any_d   = start_any;
          early_d = 1'b0;
          state_d = S_ACCUM;
        end
      end

      S_ACCUM: begin
        if (w_accept) begin
          if (cnt_q != {CNT_W{1'b1}}) begin
            cnt_d = cnt_q + 1'b1;
          end

          if (any_q) begin
            if (w_in.bHit) begin
              acc_d = w_in;
            end
          end else if (w_closer) begin
            acc_d = w_in;
          end

          // in_last wins over early-out: a hit on the final batch is a
          // normal completion, not an early termination.
          if (in_last) begin
            state_d = S_DONE;
          end else if (any_q && w_in.bHit) begin
            early_d = 1'b1;
            state_d = S_DRAIN;
          end
        end
      end

      S_DRAIN: begin
        if (w_accept && in_last) begin
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Every output is a decode of, or a copy of, a register.
  assign start_ready = (state_q == S_IDLE);
  assign in_ready    = (state_q == S_ACCUM) || (state_q == S_DRAIN);
  assign out_valid   = (state_q == S_DONE);
  assign out_hit     = acc_q;
  assign out_batches = cnt_q;
  assign out_early   = early_q;

endmodule
`default_nettype wire

// File: tb/tb_closest_hit_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : tb_closest_hit_accumulator
// Purpose  : Directed, table-driven bench for closest_hit_accumulator. A
//            second instance with CNT_W=2 shares all inputs and is used for
//            counter saturation.
// Revision : 1.0 - initial release
// ============================================================================
module tb_closest_hit_accumulator;

  localparam int HIT_W = 81;
  localparam logic [31:0] INF = 32'h7FFF_FFFF;

  typedef struct {
    bit          hit;
    logic [31:0] t;
    logic [15:0] pi;
    bit          last;
  } batch_t;

  typedef struct {
    bit          any;
    int          first;
    int          nb;
    int          hold;
    bit          gaps;
    bit          exp_hit;
    logic [31:0] exp_t;
    logic [15:0] exp_pi;
    int          exp_b;
    bit          exp_early;
  } ray_t;

  logic             clk;
  logic             reset;
  logic             start;
  logic             start_any;
  logic             in_valid;
  logic [HIT_W-1:0] in_hit;
  logic             in_last;
  logic             out_ready;

  logic             start_ready, in_ready, out_valid, out_early;
  logic [HIT_W-1:0] out_hit;
  logic [7:0]       out_batches;

  logic             start_ready2, in_ready2, out_valid2, out_early2;
  logic [HIT_W-1:0] out_hit2;
  logic [1:0]       out_batches2;

  int n_cmp = 0;
  int n_err = 0;

  batch_t bt[20];
  ray_t   rt[5];

  closest_hit_accumulator #(.CNT_W(8)) dut (
    .clk(clk), .reset(reset),
    .start(start), .start_any(start_any), .start_ready(start_ready),
    .in_valid(in_valid), .in_ready(in_ready), .in_hit(in_hit), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_hit(out_hit),
    .out_batches(out_batches), .out_early(out_early)
  );

  closest_hit_accumulator #(.CNT_W(2)) dut2 (
    .clk(clk), .reset(reset),
    .start(start), .start_any(start_any), .start_ready(start_ready2),
    .in_valid(in_valid), .in_ready(in_ready2), .in_hit(in_hit), .in_last(in_last),
    .out_valid(out_valid2), .out_ready(out_ready), .out_hit(out_hit2),
    .out_batches(out_batches2), .out_early(out_early2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Opaque Bary field is derived from PI so carry-through is checked too.
  function automatic logic [HIT_W-1:0] mkhit(bit h, logic [31:0] t, logic [15:0] pi);
    return {h, t, pi, pi, ~pi};
  endfunction

  function automatic logic [HIT_W-1:0] cleared();
    return {1'b0, INF, 48'h0};
  endfunction

  task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Entered and left at posedge+1.
  task automatic do_start(bit any);
    chk("start_ready_idle", start_ready, 1);
    start     = 1'b1;
    start_any = any;
    // A valid batch in IDLE must be ignored.
    in_valid  = 1'b1;
    in_hit    = mkhit(1, 32'h0, 16'd99);
    in_last   = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic feed(batch_t b, int gap);
    repeat (gap) begin
      @(posedge clk); #1;
    end
    in_hit   = mkhit(b.hit, b.t, b.pi);
    in_last  = b.last;
    in_valid = 1'b1;
    chk("in_ready_batch", in_ready, 1);
    chk("out_valid_before_last", out_valid, 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic run_ray(int r, bit release_out);
    logic [HIT_W-1:0] exp_hit;
    int               exp_b2;
    exp_hit = rt[r].exp_hit ? mkhit(1, rt[r].exp_t, rt[r].exp_pi) : cleared();
    exp_b2  = (rt[r].exp_b > 3) ? 3 : rt[r].exp_b;
    do_start(rt[r].any);
    for (int i = 0; i < rt[r].nb; i++) begin
      feed(bt[rt[r].first + i], rt[r].gaps ? int'($urandom_range(0, 2)) : 0);
    end
    // One cycle after the accepting edge of the last batch.
    chk("out_valid", out_valid, 1);
    chk("in_ready_done", in_ready, 0);
    chk("start_ready_done", start_ready, 0);
    chk("out_hit", out_hit, exp_hit);
    chk("out_batches", out_batches, rt[r].exp_b);
    chk("out_early", out_early, rt[r].exp_early);
    chk("d2_out_valid", out_valid2, 1);
    chk("d2_out_hit", out_hit2, exp_hit);
    chk("d2_out_batches", out_batches2, exp_b2);
    chk("d2_out_early", out_early2, rt[r].exp_early);
    chk("d2_ready", {start_ready2, in_ready2}, 2'b00);
    for (int c = 0; c < rt[r].hold; c++) begin
      @(posedge clk); #1;
      chk("hold_out_valid", out_valid, 1);
      chk("hold_out_hit", out_hit, exp_hit);
      chk("hold_out_batches", out_batches, rt[r].exp_b);
      chk("hold_in_ready", in_ready, 0);
      chk("hold_start_ready", start_ready, 0);
    end
    if (release_out) begin
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("released_start_ready", start_ready, 1);
      chk("released_out_valid", out_valid, 0);
    end
  endtask

  initial begin
    // Ray 0: closest-hit
    bt[0]  = '{1, 32'h0005_0000, 16'd1,  0};
    bt[1]  = '{1, 32'h0002_0000, 16'd2,  0};
    bt[2]  = '{0, 32'h0001_0000, 16'd3,  0};
    bt[3]  = '{1, 32'h0003_0000, 16'd4,  1};
    // Ray 1: tie keeps earlier
    bt[4]  = '{1, 32'h0002_0000, 16'd7,  0};
    bt[5]  = '{1, 32'h0002_0000, 16'd9,  1};
    // Ray 2: no hits (small T on misses must not win)
    bt[6]  = '{0, 32'h0001_0000, 16'd5,  0};
    bt[7]  = '{0, 32'h0000_8000, 16'd6,  0};
    bt[8]  = '{0, 32'h0000_0000, 16'd8,  1};
    // Ray 3: any-hit early-out
    bt[9]  = '{0, 32'h0000_8000, 16'd10, 0};
    bt[10] = '{1, 32'h0004_0000, 16'd11, 0};
    bt[11] = '{1, 32'h0001_0000, 16'd12, 0};
    bt[12] = '{0, 32'h0000_8000, 16'd13, 1};
    // Ray 4: six batches with gaps, saturates the 2-bit counter
    bt[13] = '{0, 32'h0001_0000, 16'd14, 0};
    bt[14] = '{1, 32'h0003_0000, 16'd20, 0};
    bt[15] = '{0, 32'h0000_8000, 16'd15, 0};
    bt[16] = '{0, 32'h0000_4000, 16'd16, 0};
    bt[17] = '{1, 32'h0001_8000, 16'd21, 0};
    bt[18] = '{0, 32'h0000_2000, 16'd17, 1};
    bt[19] = '{0, 32'h0, 16'd0, 1};

    //        any first nb hold gaps hit  T             PI      b  early
    rt[0] = '{0,  0,   4,  5,   0,   1,   32'h0002_0000, 16'd2,  4, 0};
    rt[1] = '{0,  4,   2,  0,   0,   1,   32'h0002_0000, 16'd7,  2, 0};
    rt[2] = '{0,  6,   3,  0,   0,   0,   INF,           16'd0,  3, 0};
    rt[3] = '{1,  9,   4,  0,   0,   1,   32'h0004_0000, 16'd11, 2, 1};
    rt[4] = '{0,  13,  6,  0,   1,   1,   32'h0001_8000, 16'd21, 6, 0};

    reset = 1'b1; start = 1'b0; start_any = 1'b0; in_valid = 1'b0;
    in_hit = '0; in_last = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;

    chk("rst_out_valid", out_valid, 0);
    chk("rst_start_ready", start_ready, 1);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_hit", out_hit, cleared());
    chk("rst_out_batches", out_batches, 0);
    chk("rst_out_early", out_early, 0);

    for (int r = 0; r < 5; r++) begin
      run_ray(r, 1'b1);
    end

    // Reset after two accepted batches.
    do_start(1'b0);
    feed(bt[0], 0);
    feed(bt[1], 0);
    reset = 1'b1;
    #1;
    chk("midray_rst_in_ready", in_ready, 0);
    chk("midray_rst_out_valid", out_valid, 0);
    chk("midray_rst_out_batches", out_batches, 0);
    chk("midray_rst_out_hit", out_hit, cleared());
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    run_ray(0, 1'b1);

    // Reset while the result is being offered.
    run_ray(1, 1'b0);
    reset = 1'b1;
    #1;
    chk("done_rst_out_valid", out_valid, 0);
    chk("done_rst_out_hit", out_hit, cleared());
    chk("done_rst_start_ready", start_ready, 1);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    run_ray(3, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/closest_hit_accumulator.md
# closest_hit_accumulator

Sequential reduction stage directly downstream of the per-cycle closest-hit / any-hit primitive test. A BVH leaf traversal presents one combinational batch result (`HitData`, one per primitive-test batch) per cycle. This block folds all batches of one ray into a single final `HitData`, using the closest-hit rule or an any-hit early-out. It then hands the result to shading over a valid/ready handshake.

## Interface
Parameters:
- `CNT_W`, default 8: width of the batch counter.

Ports:
- `clk`  in  1: system clock.
- `reset`  in  1: asynchronous, active-high reset.
- `start`  in  1: begin a new ray. Accepted only when `start_ready`=1.
- `start_any`  in  1: sampled with `start`. 1 selects any-hit mode for this ray; 0 selects closest-hit mode.
- `start_ready`  out  1: high only in IDLE.
- `in_valid`  in  1: batch result valid.
- `in_ready`  out  1: high in ACCUM and DRAIN.
- `in_hit`  in  `$bits(HitData)`: batch result. Fields used: `bHit` and `T` (Fixed). All other fields are carried opaquely.
- `in_last`  in  1: this batch is the ray's final batch.
- `out_valid`  out  1: final result valid.
- `out_ready`  in  1: downstream accepts.
- `out_hit`  out  `$bits(HitData)`: final hit.
- `out_batches`  out  `CNT_W`: number of batches accepted for this ray. Saturates at all-ones.
- `out_early`  out  1: any-hit mode terminated before `in_last`.

## Operation
States: IDLE, ACCUM, DRAIN, DONE.

- **Reset (asynchronous, any state):**
  - State → IDLE.
  - Accumulator `acc.bHit`=0, `acc.T`=FixedInf(), other fields 0.
  - Counter=0, mode=0, `out_early`=0.
  - `out_valid`=0, `out_hit`=all-zero struct except `T`=FixedInf(), `out_batches`=0.
- **IDLE, `start`=1:**
  - Load the accumulator with the cleared value above, counter=0, mode=`start_any`, early=0.
  - Go to ACCUM.
  - `in_valid` in IDLE is ignored and not acknowledged.
- **ACCUM, batch accepted (`in_valid && in_ready`):**
  - Counter increments, saturating.
  - Closest-hit mode: replace `acc` with `in_hit` only when `in_hit.bHit`=1 and `acc.T > in_hit.T` (strict). Equal `T` keeps the earlier batch. A non-hit batch never replaces `acc`, whatever its `T`.
  - Any-hit mode: if `in_hit.bHit`=1, copy `in_hit` into `acc`.
  - If `in_last`=1, go to DONE.
  - Else, in any-hit mode with `in_hit.bHit`=1, set early=1 and go to DRAIN.
  - Else stay in ACCUM.
- **DRAIN:**
  - Accept and discard batches. Do not count them; `acc` is unchanged.
  - Go to DONE on an accepted batch with `in_last`=1.
- **DONE:**
  - `out_valid`=1, with `out_hit`=`acc`, `out_batches`, and `out_early` held stable.
  - On `out_valid && out_ready`, go to IDLE.
  - `start` is not accepted in DONE.
- **Zero-hit ray:** the result has `bHit`=0 and `T`=FixedInf().
- **Counter saturation:** `out_batches` sticks at 2^CNT_W−1. Accumulation continues correctly past saturation.

## Timing
- All outputs are registered. `in_ready` and `start_ready` are decoded from state only and never depend on `in_valid`.
- Latency: `out_valid` rises on the clock edge after the accepting edge of the `in_last` batch, i.e. 1 cycle.
- Throughput: one batch per cycle in ACCUM and DRAIN.
- Minimum ray turnaround: start (1 cycle) + N batches + 1 cycle DONE + 1 cycle IDLE.
- `in_ready` drops in the same cycle the state enters DONE, so no batch is accepted after `in_last`.
- Backpressure: `out_valid` stays high and `out_*` are stable until `out_ready`=1. This can last any number of cycles.
- Asynchronous `reset` asserted mid-ray drops `out_valid`/`in_ready` immediately. The partial result is lost. After reset deasserts, the first accepted `start` begins from the cleared state.

## Test plan
- **Closest-hit:** start(any=0); batches T=5.0 hit, T=2.0 hit, T=1.0 miss, T=3.0 hit(last) → out_hit.T=2.0, bHit=1, out_batches=4, out_early=0, `out_valid` one cycle after the last accept.
- **Tie and no-hit:**
  - Batches T=2.0 hit PI=7, then T=2.0 hit PI=9 (last) → PI=7.
  - Separate ray with 3 miss batches → bHit=0, T=FixedInf, out_batches=3.
- **Any-hit early-out:** start(any=1); batches miss, hit T=4.0, hit T=1.0, miss(last) → out_hit.T=4.0, out_early=1, out_batches=2, `in_ready` high through all 4 batches.
- **Backpressure:** hold `out_ready`=0 for 5 cycles → `out_valid` and `out_hit` stable, `in_ready`=0, `start_ready`=0. Release → IDLE next cycle, `start_ready`=1.
- **Gaps and saturation:** with CNT_W=2, 6 batches with random `in_valid` gaps, hit T=1.5 in batch 5 → out_batches=3, T=1.5.
- **Reset mid-ray:** assert `reset` after 2 batches → `out_valid`=0 and `in_ready`=0 immediately. A new ray afterwards matches the golden result.
